// File: rtl/rr_intf_arbiter_pkg.sv
// Shared types for the round-robin interface arbiter: FSM state encoding and
// an index-width helper used to size pointers and counters.
package rr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  // Bits needed to index n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_intf_arbiter_pick.sv
// Rotating-priority encoder: returns the first requester at or after ptr_i,
// wrapping past the top index, plus a flag saying any request is present.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             any_o,
  output logic [IDX_W-1:0] winner_o
);

  int slot;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    any_o    = |req_i;
    winner_o = '0;
    slot     = 0;
    // Scan from the farthest offset down so the nearest request overwrites last.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      slot = int'(ptr_i) + i;
      if (slot >= N_REQ) slot = slot - N_REQ;
      if (req_i[slot]) winner_o = IDX_W'(slot);
    end
  end

endmodule

// File: rtl/rr_intf_arbiter.sv
// Round-robin owner arbitration for one shared interface: one-cycle grant
// latency, hold-timer revoke, and a mandatory one-cycle gap between owners.
module rr_intf_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         rel,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     busy,
  output logic                     timeout,
  output logic [CNT_W-1:0]         grant_cnt
);

  localparam int IDX_W  = idx_w(N_REQ);
  localparam int HOLD_W = idx_w(HOLD_MAX);

  arb_state_t       state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [HOLD_W-1:0] hold_q;
  logic [N_REQ-1:0] gnt_q;
  logic [IDX_W-1:0] gnt_id_q;
  logic             busy_q;
  logic             timeout_q;
  logic [CNT_W-1:0] grant_cnt_q;

  logic             pick_any;
  logic [IDX_W-1:0] pick_id;
  logic [N_REQ-1:0] win_onehot;
  logic [IDX_W-1:0] ptr_next;
  logic             owner_done;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .any_o    (pick_any),
    .winner_o (pick_id)
  );

  always_comb begin
    win_onehot          = '0;
    win_onehot[pick_id] = 1'b1;
    ptr_next            = (pick_id == IDX_W'(N_REQ - 1)) ? '0 : pick_id + 1'b1;
    // Explicit release or dropping req both end the tenure; either beats the timer.
    owner_done          = rel[gnt_id_q] || !req[gnt_id_q];
  end

  // NOTE: state is updated with non-blocking assignments only, and the reset
  // branch is asynchronous so gnt drops the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hold_q      <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      grant_cnt_q <= '0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        IDLE, GAP: begin
          if (pick_any) begin
            state_q     <= GRANT;
            gnt_q       <= win_onehot;
            gnt_id_q    <= pick_id;
            busy_q      <= 1'b1;
            grant_cnt_q <= grant_cnt_q + 1'b1;
            ptr_q       <= ptr_next;
            hold_q      <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        GRANT: begin
          if (owner_done) begin
            state_q <= GAP;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (hold_q == HOLD_W'(HOLD_MAX - 1)) begin
            state_q   <= GAP;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign busy      = busy_q;
  assign timeout   = timeout_q;
  assign grant_cnt = grant_cnt_q;

endmodule

// File: tb/tb_rr_intf_arbiter.sv
// Bench for rr_intf_arbiter: transaction-level owner model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rr_intf_arbiter;

  localparam int N  = 4;
  localparam int HM = 16;
  localparam int CW = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] rel;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         busy;
  logic         timeout;
  logic [CW-1:0] grant_cnt;

  rr_intf_arbiter #(.N_REQ(N), .HOLD_MAX(HM), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .rel       (rel),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .busy      (busy),
    .timeout   (timeout),
    .grant_cnt (grant_cnt)
  );

  always #5 clk = ~clk;

  // Model view: who owns the resource (-1 = nobody), how many edges it has
  // owned it for, where the next search starts, and how many grants so far.
  typedef struct packed {
    int owner;
    int ptr;
    int held;
    int cnt;
    int last_id;
    bit to;
  } mst_t;

  mst_t m;
  int   n_pass  = 0;
  int   n_total = 0;
  bit   cmp_en  = 1'b0;

  function automatic mst_t model_reset();
    mst_t r;
    r.owner = -1; r.ptr = 0; r.held = 0; r.cnt = 0; r.last_id = 0; r.to = 1'b0;
    return r;
  endfunction

  // Any cycle without an owner (idle or the gap after a tenure) arbitrates.
  function automatic mst_t model_step(mst_t s, logic [N-1:0] rq, logic [N-1:0] rl);
    mst_t n;
    int   c;
    n    = s;
    n.to = 1'b0;
    if (s.owner >= 0) begin
      n.held = s.held + 1;
      if (rl[s.owner] || !rq[s.owner]) begin
        n.owner = -1;
      end else if (n.held == HM) begin
        n.owner = -1;
        n.to    = 1'b1;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        c = (s.ptr + k) % N;
        if (n.owner < 0 && rq[c]) begin
          n.owner   = c;
          n.held    = 0;
          n.cnt     = s.cnt + 1;
          n.ptr     = (c + 1) % N;
          n.last_id = c;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_step(m, req, rel);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_gnt", 32'(gnt), (m.owner >= 0) ? (32'd1 << m.owner) : 32'd0);
      check("m_busy", 32'(busy), 32'(m.owner >= 0));
      check("m_timeout", 32'(timeout), 32'(m.to));
      check("m_grant_cnt", 32'(grant_cnt), 32'(m.cnt & ((1 << CW) - 1)));
      if (m.owner >= 0) check("m_gnt_id", 32'(gnt_id), 32'(m.last_id));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_gnt_id"}, 32'(gnt_id), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
    check({tag, "_cnt"}, 32'(grant_cnt), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    rel   = '0;
    @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
  endtask

  int ids[5];
  int nlog;
  bit prev_busy;
  bit to_seen;

  initial begin
    rst_n = 1'b0;
    req   = '0;
    rel   = '0;
    step(2);
    cmp_en = 1'b1;
    check_reset_vals("por");
    rst_n = 1'b1;

    // Single requester, never releases: 16-cycle tenure, timeout, regrant.
    do_reset();
    req = 4'b0001;
    step(1);
    check("s1_first_gnt", 32'(gnt), 32'h1);
    check("s1_first_cnt", 32'(grant_cnt), 32'd1);
    step(15);
    check("s1_still_owned", 32'(gnt), 32'h1);
    step(1);
    check("s1_timeout", 32'(timeout), 32'd1);
    check("s1_gap_gnt", 32'(gnt), 32'h0);
    step(1);
    check("s1_regrant", 32'(gnt), 32'h1);
    check("s1_cnt2", 32'(grant_cnt), 32'd2);
    check("s1_to_clear", 32'(timeout), 32'd0);

    // All request, each owner releases in its third cycle.
    do_reset();
    req = 4'b1111;
    prev_busy = 1'b0;
    nlog = 0;
    to_seen = 1'b0;
    repeat (18) begin
      step(1);
      if (busy && !prev_busy && nlog < 5) begin
        ids[nlog] = int'(gnt_id);
        nlog++;
      end
      prev_busy = busy;
      if (timeout) to_seen = 1'b1;
      rel = '0;
      if (m.owner >= 0 && m.held == 2) rel[m.owner] = 1'b1;
    end
    rel = '0;
    check("s2_ngrants", 32'(nlog), 32'd5);
    check("s2_order0", 32'(ids[0]), 32'd0);
    check("s2_order1", 32'(ids[1]), 32'd1);
    check("s2_order2", 32'(ids[2]), 32'd2);
    check("s2_order3", 32'(ids[3]), 32'd3);
    check("s2_order4", 32'(ids[4]), 32'd0);
    check("s2_no_timeout", 32'(to_seen), 32'd0);

    // Pointer at 2 after granting 1; requests 0 and 1 -> wrap to 0, then 1.
    do_reset();
    req = 4'b0010;
    step(1);
    check("s3_gnt1", 32'(gnt), 32'h2);
    req = 4'b0000;
    step(1);
    req = 4'b0011;
    step(1);
    check("s3_wrap_gnt0", 32'(gnt), 32'h1);
    check("s3_wrap_id0", 32'(gnt_id), 32'd0);
    req = 4'b0010;
    step(2);
    check("s3_next_gnt1", 32'(gnt), 32'h2);

    // Non-owner release ignored; owner dropping req ends the tenure quietly.
    do_reset();
    req = 4'b0101;
    step(1);
    check("s4_gnt0", 32'(gnt), 32'h1);
    rel = 4'b0100;
    step(1);
    rel = '0;
    check("s4_rel_ignored", 32'(gnt), 32'h1);
    req = 4'b0100;
    step(1);
    check("s4_gap_gnt", 32'(gnt), 32'h0);
    check("s4_gap_busy", 32'(busy), 32'd0);
    check("s4_gap_to", 32'(timeout), 32'd0);
    step(1);
    check("s4_gnt2", 32'(gnt), 32'h4);

    // Release on the last allowed cycle: release wins, no timeout.
    do_reset();
    req = 4'b0001;
    step(16);
    check("s5_last_cycle", 32'(gnt), 32'h1);
    rel = 4'b0001;
    step(1);
    rel = '0;
    check("s5_gap_gnt", 32'(gnt), 32'h0);
    check("s5_no_timeout", 32'(timeout), 32'd0);
    step(1);
    check("s5_regrant", 32'(gnt), 32'h1);

    // Asynchronous reset mid-tenure at grant_cnt=5.
    do_reset();
    req = 4'b0001;
    rel = 4'b0001;
    step(9);
    rel = '0;
    check("s6_cnt5", 32'(grant_cnt), 32'd5);
    check("s6_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("s6_async");
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1000;
    step(1);
    check("s6_gnt3", 32'(gnt), 32'h8);
    check("s6_id3", 32'(gnt_id), 32'd3);
    check("s6_cnt1", 32'(grant_cnt), 32'd1);

    // Random traffic: short tenures, then sparse changes to reach the hold limit.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(7) == 0) req[b] = ~req[b];
        rel[b] = ($urandom_range(5) == 0);
      end
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(63) == 0) req[b] = ~req[b];
        rel[b] = ($urandom_range(63) == 0);
      end
    end
    req = '0;
    rel = '0;
    step(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
